// File: rtl/result_uart_tx.sv
// result_uart_tx: serialises the NUM_CHARS-byte ASCII display string as 8N1 UART
// frames, first character = top byte, each byte LSB first, frames back to back.
// A null byte goes out as a space. Defining CRLF_APPEND_EN appends 0x0D, 0x0A
// frames after the last display character.
module result_uart_tx #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned NUM_CHARS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*NUM_CHARS-1:0] display,
    input  logic                   send,
    output logic                   busy,
    output logic                   done,
    output logic                   tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

`ifdef CRLF_APPEND_EN
    localparam int unsigned NumFrames = NUM_CHARS + 2;
`else
    localparam int unsigned NumFrames = NUM_CHARS;
`endif

    localparam int unsigned BufW  = 8 * NumFrames;
    localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CharW = (NumFrames > 1) ? $clog2(NumFrames) : 1;

    localparam logic [CntW-1:0]  CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CharW-1:0] CharLast = CharW'(NumFrames - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [CharW-1:0] char_q, char_d;
    logic [BufW-1:0]  buf_q, buf_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [BufW-1:0]  msg;
    logic [7:0]       cur_raw;
    logic [7:0]       cur_byte;
    logic [2:0]       bit_next;
    logic             bit_end;

    // Message image captured at acceptance; the trailer frames ride along in the
    // same shift buffer so every frame is handled identically.
`ifdef CRLF_APPEND_EN
    assign msg = {display, 8'h0D, 8'h0A};
`else
    assign msg = display;
`endif

    // Character currently on the wire is always the top byte of the shift buffer.
    assign cur_raw  = buf_q[BufW-1 -: 8];
    assign cur_byte = (cur_raw == 8'h00) ? 8'h20 : cur_raw;
    assign bit_end  = (cnt_q == CntLast);
    assign bit_next = bit_q + 3'd1;

    // Next-state logic: baud timing, bit/char sequencing and the registered line value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        char_d  = char_q;
        buf_d   = buf_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                bit_d  = '0;
                if (send) begin
                    buf_d   = msg;
                    char_d  = '0;
                    state_d = StStart;
                    // Start bit goes out on the accepting edge itself.
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                    tx_d    = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_next;
                        tx_d  = cur_byte[bit_next];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (char_q == CharLast) begin
                        // A send seen on this edge is dropped: we are not in idle yet.
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Next frame follows with no idle gap.
                        char_d  = char_q + 1'b1;
                        buf_d   = buf_q << 8;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any frame in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            buf_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            buf_q   <= buf_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx at CLKS_PER_BIT=16. Stimulus pushes expected frames
// (byte and start cycle), done cycle and busy window; a negedge monitor decodes
// the line and checks against those expectations.
module tb_result_uart_tx;

    localparam int unsigned CPB = 16;
    localparam int unsigned NCH = 5;
`ifdef CRLF_APPEND_EN
    localparam int NFR = NCH + 2;
`else
    localparam int NFR = NCH;
`endif
    localparam int FRAME = 10 * CPB;
    localparam int MSG   = NFR * FRAME;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [39:0] display = '0;
    logic        send = 1'b0;
    logic        busy;
    logic        done;
    logic        tx;

    always #5 clk = ~clk;

    result_uart_tx #(
        .CLK_HZ   (16),
        .BAUD     (1),
        .NUM_CHARS(NCH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .display(display),
        .send   (send),
        .busy   (busy),
        .done   (done),
        .tx     (tx)
    );

    typedef struct {
        logic [7:0] b;
        int         start;
    } frame_t;

    frame_t exp_frames[$];
    int     exp_done[$];
    int     busy_from = 0;
    int     busy_to   = 0;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rst_seen = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    function automatic logic exp_level(input logic [7:0] b, input int bi);
        if (bi == 0) return 1'b0;
        if (bi >= 9) return 1'b1;
        return b[bi-1];
    endfunction

    // Monitor state
    bit         active = 1'b0;
    int         f0 = 0;
    frame_t     cur;
    logic [7:0] got;
    bit         lvl_err;
    logic       exp_b;
    int         want;
    int         pos;
    int         bi;

    always @(negedge clk) begin
        if (rst_seen) begin
            active = 1'b0;
            total++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset_state: cyc=%0d tx=%b busy=%b done=%b, want 1 0 0",
                         cyc, tx, busy, done);
            end
        end else begin
            exp_b = (cyc >= busy_from && cyc < busy_to);
            total++;
            if (busy !== exp_b) begin
                bad++;
                if (bad <= 20) $display("FAIL busy: cyc=%0d got %b want %b", cyc, busy, exp_b);
            end

            if (done === 1'b1) begin
                total++;
                if (exp_done.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected: cyc=%0d got done=1 want 0", cyc);
                end else begin
                    want = exp_done.pop_front();
                    if (cyc != want) begin
                        bad++;
                        $display("FAIL done_time: got cyc %0d want cyc %0d", cyc, want);
                    end
                end
            end else if (exp_done.size() > 0 && cyc > exp_done[0]) begin
                total++;
                bad++;
                $display("FAIL done_missing: cyc=%0d got none want pulse at %0d", cyc, exp_done[0]);
                void'(exp_done.pop_front());
            end

            if (!active && tx !== 1'b1) begin
                total++;
                if (exp_frames.size() == 0) begin
                    bad++;
                    $display("FAIL frame_unexpected: cyc=%0d got tx=%b want 1", cyc, tx);
                end else begin
                    cur = exp_frames.pop_front();
                    if (cyc != cur.start) begin
                        bad++;
                        $display("FAIL frame_start: got cyc %0d want cyc %0d", cyc, cur.start);
                    end
                    active  = 1'b1;
                    f0      = cyc;
                    got     = '0;
                    lvl_err = 1'b0;
                end
            end

            if (active) begin
                pos = cyc - f0;
                bi  = pos / CPB;
                if (tx !== exp_level(cur.b, bi)) lvl_err = 1'b1;
                if ((pos % CPB) == CPB / 2 && bi >= 1 && bi <= 8) got[bi-1] = tx;
                if (pos == FRAME - 1) begin
                    total++;
                    if (got !== cur.b || lvl_err) begin
                        bad++;
                        $display("FAIL frame: got %h (timing_err=%0d) want %h", got, lvl_err,
                                 cur.b);
                    end
                    active = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [39:0] d, output int n);
        logic [7:0] b;
        display = d;
        send    = 1'b1;
        n       = cyc + 1;
        for (int k = 0; k < int'(NCH); k++) begin
            b = d[8*(int'(NCH)-1-k) +: 8];
            if (b == 8'h00) b = 8'h20;
            exp_frames.push_back('{b, n + k * FRAME});
        end
`ifdef CRLF_APPEND_EN
        exp_frames.push_back('{8'h0D, n + int'(NCH) * FRAME});
        exp_frames.push_back('{8'h0A, n + (int'(NCH) + 1) * FRAME});
`endif
        exp_done.push_back(n + MSG);
        busy_from = n;
        busy_to   = n + MSG;
        tick(1);
        send = 1'b0;
    endtask

    task automatic ignored_send();
        display = {8'($urandom()), 32'($urandom())};
        send    = 1'b1;
        tick(1);
        send = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < MSG + 100; i++) begin
            if (exp_frames.size() == 0 && exp_done.size() == 0 && !active) begin
                idle = 1'b1;
                break;
            end
            tick(1);
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL timeout: got %0d frames/%0d dones pending want 0",
                     exp_frames.size(), exp_done.size());
            exp_frames.delete();
            exp_done.delete();
        end
    endtask

    function automatic logic [39:0] rand_disp();
        logic [39:0] r;
        for (int i = 0; i < 5; i++)
            r[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(32, 126));
        return r;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [39:0] d;

        // Reset for 3 cycles, then idle with no send.
        tick(3);
        reset = 1'b0;
        tick(60);

        send_msg(40'h41422B3132, n);
        wait_idle();

        send_msg(40'h4100000042, n);
        wait_idle();

        // Sends while busy and on the done edge are dropped; one cycle later is accepted.
        send_msg(rand_disp(), n);
        tick(99);
        ignored_send();
        tick(n + MSG - 1 - cyc);
        ignored_send();
        send_msg(rand_disp(), n);
        wait_idle();

        // Random strings; display disturbed mid-message.
        for (int m = 0; m < 4; m++) begin
            send_msg(rand_disp(), n);
            tick(37 + m * 50);
            display = rand_disp();
            wait_idle();
        end

        send_msg(40'h4552522020, n);
        wait_idle();

        // Reset during the third frame's data bits.
        d = rand_disp();
        send_msg(d, n);
        tick(n + 2 * FRAME + CPB + 40 - cyc);
        reset = 1'b1;
        tick(1);
        exp_frames.delete();
        exp_done.delete();
        busy_to = cyc;
        reset   = 1'b0;
        tick(30);
        send_msg(d, n);
        wait_idle();
        tick(20);

        total++;
        if (exp_frames.size() != 0 || exp_done.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d frames/%0d dones want 0", exp_frames.size(),
                     exp_done.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
